scoreboard_reg_file: RTL and testbench

SCOREBOARD_REG_FILE -- requirements
Module: scoreboard_reg_file

---
 rtl/scoreboard_reg_file_pkg.sv | 26 ++
 rtl/scoreboard_reg_file_reg_scoreboard.sv | 78 +++++++
 rtl/scoreboard_reg_file.sv | 112 +++++++++++
 tb/tb_scoreboard_reg_file.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_reg_file_pkg.sv
// Shared defaults and write-source priority encoding for the scoreboarded register file.
package scoreboard_reg_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 4;
   localparam int PC_IDX_DEF = 15;
   localparam int LR_IDX_DEF = 14;

   // Encoded in ascending priority so a larger value always wins a collision.
   typedef enum logic [1:0] {
      WSRC_NONE = 2'd0,
      WSRC_LOAD = 2'd1,
      WSRC_ALU  = 2'd2,
      WSRC_LINK = 2'd3
   } wr_src_e;

   function automatic wr_src_e wr_select(input logic link_hit,
                                         input logic alu_hit,
                                         input logic load_hit);
      if (link_hit) return WSRC_LINK;
      if (alu_hit)  return WSRC_ALU;
      if (load_hit) return WSRC_LOAD;
      return WSRC_NONE;
   endfunction

endpackage

// File: rtl/scoreboard_reg_file_reg_scoreboard.sv
// Load scoreboard: per-register busy bits, pending-load counter and sticky protocol error.
module reg_scoreboard
   import scoreboard_reg_file_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int PC_IDX = PC_IDX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_issue_i,
   input  logic [ADDR_W-1:0] ld_dest_i,
   input  logic              ld_valid_i,
   input  logic [ADDR_W-1:0] ld_ret_dest_i,
   input  logic [ADDR_W-1:0] rd_addr_a_i,
   input  logic [ADDR_W-1:0] rd_addr_b_i,
   output logic              busy_a_o,
   output logic              busy_b_o,
   output logic [ADDR_W:0]   ld_outstanding_o,
   output logic              sb_err_o
);

   localparam int                NREG     = 2**ADDR_W;
   localparam int                CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  NREG_CNT = CNT_W'(NREG);
   localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);

   logic [NREG-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic issue_pc, ret_pc, issue_conflict, ret_idle;
   logic issue_ok, ret_ok;

   assign issue_pc       = ld_issue_i && (ld_dest_i == PC_A);
   assign ret_pc         = ld_valid_i && (ld_ret_dest_i == PC_A);
   assign issue_conflict = ld_issue_i && busy_q[ld_dest_i]
                           && !(ld_valid_i && (ld_ret_dest_i == ld_dest_i));
   assign ret_idle       = ld_valid_i && !busy_q[ld_ret_dest_i];

   // Only well-formed events move the count, so a stray return can never underflow it.
   assign issue_ok = ld_issue_i && !issue_pc && !issue_conflict;
   assign ret_ok   = ld_valid_i && busy_q[ld_ret_dest_i];

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      err_d  = err_q | issue_pc | ret_pc | issue_conflict | ret_idle;
      // Clear before set: a same-cycle issue and return to one index leaves it busy.
      if (ret_ok)   busy_d[ld_ret_dest_i] = 1'b0;
      if (issue_ok) busy_d[ld_dest_i]     = 1'b1;
      if (issue_ok && !ret_ok) begin
         if (cnt_q != NREG_CNT) cnt_d = cnt_q + CNT_W'(1);
      end else if (ret_ok && !issue_ok) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy_a_o = busy_q[rd_addr_a_i] && (rd_addr_a_i != PC_A)
                     && !(ld_valid_i && (ld_ret_dest_i == rd_addr_a_i));
   assign busy_b_o = busy_q[rd_addr_b_i] && (rd_addr_b_i != PC_A)
                     && !(ld_valid_i && (ld_ret_dest_i == rd_addr_b_i));

   assign ld_outstanding_o = cnt_q;
   assign sb_err_o         = err_q;

endmodule

// File: rtl/scoreboard_reg_file.sv
// Two-read-port register file with PC alias, link write, bypassed reads and a load scoreboard.
module scoreboard_reg_file
   import scoreboard_reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int PC_IDX = PC_IDX_DEF,
   parameter int LR_IDX = LR_IDX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              busy_a,
   output logic              busy_b,
   output logic              stall,
   input  logic [DATA_W-1:0] pc_val,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              link_en,
   output logic              wr_pc,
   output logic [DATA_W-1:0] pc_data,
   input  logic              ld_issue,
   input  logic [ADDR_W-1:0] ld_dest,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_ret_dest,
   input  logic [DATA_W-1:0] ld_data,
   output logic [ADDR_W:0]   ld_outstanding,
   output logic              sb_err
);

   localparam int                NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
   localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(LR_IDX);

   logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [1:0][ADDR_W-1:0]      rd_addr;
   logic [1:0][DATA_W-1:0]      rd_data;

   always_comb begin
      // NOTE: full default first; a path that leaves regs_d unassigned would infer a latch.
      regs_d = regs_q;
      for (int i = 0; i < NREG; i++) begin
         if (i != PC_IDX) begin
            case (wr_select(link_en && (i == LR_IDX),
                            wr_en && (wr_addr == ADDR_W'(i)),
                            ld_valid && (ld_ret_dest == ADDR_W'(i))))
               WSRC_LINK: regs_d[i] = pc_val;
               WSRC_ALU:  regs_d[i] = wr_data;
               WSRC_LOAD: regs_d[i] = ld_data;
               default:   ;
            endcase
         end
      end
   end

   // NOTE: the array is plain flops with an async clear because reset must zero every register;
   // state is updated with <= so all entries sample pre-edge values together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) regs_q <= '0;
      else        regs_q <= regs_d;
   end

   assign rd_addr = {rd_addr_b, rd_addr_a};

   // Same-cycle writes are forwarded with the write priority; bypass is muted while in reset.
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < 2; p++) begin
         case (wr_select(link_en && (rd_addr[p] == LR_A),
                         wr_en && (rd_addr[p] == wr_addr),
                         ld_valid && (rd_addr[p] == ld_ret_dest)))
            WSRC_LINK: rd_data[p] = pc_val;
            WSRC_ALU:  rd_data[p] = wr_data;
            WSRC_LOAD: rd_data[p] = ld_data;
            default:   rd_data[p] = regs_q[rd_addr[p]];
         endcase
         if (!reset)             rd_data[p] = '0;
         if (rd_addr[p] == PC_A) rd_data[p] = pc_val;
      end
   end

   assign rd_data_a = rd_data[0];
   assign rd_data_b = rd_data[1];

   assign wr_pc   = wr_en && (wr_addr == PC_A);
   assign pc_data = wr_data;

   reg_scoreboard #(
      .ADDR_W (ADDR_W),
      .PC_IDX (PC_IDX)
   ) u_sb (
      .clk              (clk),
      .rst_n            (reset),
      .ld_issue_i       (ld_issue),
      .ld_dest_i        (ld_dest),
      .ld_valid_i       (ld_valid),
      .ld_ret_dest_i    (ld_ret_dest),
      .rd_addr_a_i      (rd_addr_a),
      .rd_addr_b_i      (rd_addr_b),
      .busy_a_o         (busy_a),
      .busy_b_o         (busy_b),
      .ld_outstanding_o (ld_outstanding),
      .sb_err_o         (sb_err)
   );

   assign stall = busy_a | busy_b;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Self-checking bench for scoreboard_reg_file: vector table, write/read-back queue, load corner sequences.
module tb_scoreboard_reg_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic        busy_a, busy_b, stall;
   logic [31:0] pc_val;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        link_en;
   logic        wr_pc;
   logic [31:0] pc_data;
   logic        ld_issue;
   logic [3:0]  ld_dest;
   logic        ld_valid;
   logic [3:0]  ld_ret_dest;
   logic [31:0] ld_data;
   logic [4:0]  ld_outstanding;
   logic        sb_err;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic        wr_en;
      logic [3:0]  wr_addr;
      logic [31:0] wr_data;
      logic        link_en;
      logic [31:0] pc;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [31:0] ea;
      logic [31:0] eb;
      logic        ewpc;
   } vec_t;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
   } exp_t;

   vec_t vecs[8];
   exp_t sbq[$];

   always #5 clk = ~clk;

   scoreboard_reg_file dut (
      .clk            (clk),
      .reset          (reset),
      .rd_addr_a      (rd_addr_a),
      .rd_addr_b      (rd_addr_b),
      .rd_data_a      (rd_data_a),
      .rd_data_b      (rd_data_b),
      .busy_a         (busy_a),
      .busy_b         (busy_b),
      .stall          (stall),
      .pc_val         (pc_val),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .link_en        (link_en),
      .wr_pc          (wr_pc),
      .pc_data        (pc_data),
      .ld_issue       (ld_issue),
      .ld_dest        (ld_dest),
      .ld_valid       (ld_valid),
      .ld_ret_dest    (ld_ret_dest),
      .ld_data        (ld_data),
      .ld_outstanding (ld_outstanding),
      .sb_err         (sb_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      rd_addr_a   = '0;
      rd_addr_b   = '0;
      pc_val      = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      link_en     = 1'b0;
      ld_issue    = 1'b0;
      ld_dest     = '0;
      ld_valid    = 1'b0;
      ld_ret_dest = '0;
      ld_data     = '0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      exp_t cur, prev;

      vecs[0] = '{1'b1, 4'd14, 32'h1111_0000, 1'b1, 32'h0000_0200, 4'd14, 4'd8,  32'h0000_0200, 32'hAAAA_AAAA, 1'b0};
      vecs[1] = '{1'b0, 4'd0,  32'h0,         1'b0, 32'h0000_0300, 4'd14, 4'd15, 32'h0000_0200, 32'h0000_0300, 1'b0};
      vecs[2] = '{1'b1, 4'd1,  32'hDEAD_BEEF, 1'b0, 32'h0,         4'd1,  4'd0,  32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[3] = '{1'b1, 4'd0,  32'h0000_0001, 1'b0, 32'h0,         4'd1,  4'd0,  32'hDEAD_BEEF, 32'h0000_0001, 1'b0};
      vecs[4] = '{1'b1, 4'd15, 32'h5555_5555, 1'b0, 32'h0000_0400, 4'd15, 4'd0,  32'h0000_0400, 32'h0000_0001, 1'b1};
      vecs[5] = '{1'b0, 4'd0,  32'h0,         1'b1, 32'h0000_0500, 4'd14, 4'd13, 32'h0000_0500, 32'h0,         1'b0};
      vecs[6] = '{1'b1, 4'd13, 32'h1234_0000, 1'b0, 32'h0,         4'd13, 4'd14, 32'h1234_0000, 32'h0000_0500, 1'b0};
      vecs[7] = '{1'b0, 4'd0,  32'h0,         1'b0, 32'hFFFF_FFFC, 4'd15, 4'd13, 32'hFFFF_FFFC, 32'h1234_0000, 1'b0};

      // Behaviour while held in reset
      reset = 1'b0;
      idle();
      @(posedge clk);
      #1;
      wr_en = 1'b1; wr_addr = 4'd15; rd_addr_b = 4'd15; rd_addr_a = 4'd3; pc_val = 32'h0000_0100;
      #1;
      check("rst_wr_pc", wr_pc, 1);
      check("rst_rd_pc", rd_data_b, 32'h0000_0100);
      check("rst_rd_a", rd_data_a, 0);
      check("rst_stall", stall, 0);
      check("rst_cnt", ld_outstanding, 0);
      check("rst_err", sb_err, 0);
      wr_addr = 4'd3; wr_data = 32'hBAD0_BAD0;
      #1;
      check("rst_no_bypass", rd_data_a, 0);
      check("rst_wr_pc_off", wr_pc, 0);
      idle();
      #1;
      reset = 1'b1;

      // ALU write, bypass then array read
      next_cycle();
      wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'hAAAA_AAAA; rd_addr_a = 4'd8;
      #3;
      check("alu_bypass", rd_data_a, 32'hAAAA_AAAA);
      next_cycle();
      rd_addr_a = 4'd8; rd_addr_b = 4'd9;
      #3;
      check("alu_array", rd_data_a, 32'hAAAA_AAAA);
      check("untouched_r9", rd_data_b, 0);

      // ALU write to PC alias plus link
      next_cycle();
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hCCCC_CCCC; link_en = 1'b1; pc_val = 32'h0000_0040;
      rd_addr_a = 4'd14; rd_addr_b = 4'd15;
      #3;
      check("pc_wr_pc", wr_pc, 1);
      check("pc_data", pc_data, 32'hCCCC_CCCC);
      check("link_bypass", rd_data_a, 32'h0000_0040);
      next_cycle();
      pc_val = 32'h0000_0080; rd_addr_a = 4'd14; rd_addr_b = 4'd15;
      #3;
      check("link_r14", rd_data_a, 32'h0000_0040);
      check("pc_read_alias", rd_data_b, 32'h0000_0080);
      check("wr_pc_idle", wr_pc, 0);

      // Table-driven bypass and priority vectors
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         link_en = vecs[i].link_en; pc_val = vecs[i].pc;
         rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
         #3;
         check($sformatf("vec%0d_a", i), rd_data_a, vecs[i].ea);
         check($sformatf("vec%0d_b", i), rd_data_b, vecs[i].eb);
         check($sformatf("vec%0d_wr_pc", i), wr_pc, vecs[i].ewpc);
      end

      // Write/read-back scoreboard: each write is pushed, popped and read back a cycle later
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         cur.addr = 4'($urandom_range(0, 13));
         cur.data = $urandom;
         if (sbq.size() > 0) begin
            prev = sbq.pop_front();
            if (cur.addr == prev.addr) cur.addr = (cur.addr == 4'd13) ? 4'd0 : cur.addr + 4'd1;
            rd_addr_a = prev.addr;
         end else begin
            prev.addr = '0;
            prev.data = '0;
         end
         wr_en = 1'b1; wr_addr = cur.addr; wr_data = cur.data; rd_addr_b = cur.addr;
         sbq.push_back(cur);
         #3;
         check($sformatf("sb_bypass%0d", k), rd_data_b, cur.data);
         if (k > 0) check($sformatf("sb_readback%0d", k), rd_data_a, prev.data);
      end
      next_cycle();
      prev = sbq.pop_front();
      rd_addr_a = prev.addr;
      #3;
      check("sb_readback_last", rd_data_a, prev.data);

      // Load to R3 returning three cycles after issue
      next_cycle();
      ld_issue = 1'b1; ld_dest = 4'd3; rd_addr_a = 4'd3;
      #3;
      check("ld3_busy_pre", busy_a, 0);
      next_cycle();
      rd_addr_a = 4'd3;
      #3;
      check("ld3_stall", stall, 1);
      check("ld3_busy", busy_a, 1);
      check("ld3_cnt1", ld_outstanding, 1);
      next_cycle();
      rd_addr_a = 4'd3;
      #3;
      check("ld3_stall_hold", stall, 1);
      next_cycle();
      ld_valid = 1'b1; ld_ret_dest = 4'd3; ld_data = 32'h1234_5678; rd_addr_a = 4'd3;
      #3;
      check("ld3_ret_busy", busy_a, 0);
      check("ld3_ret_stall", stall, 0);
      check("ld3_ret_bypass", rd_data_a, 32'h1234_5678);
      check("ld3_ret_cnt", ld_outstanding, 1);
      next_cycle();
      rd_addr_a = 4'd3;
      #3;
      check("ld3_data", rd_data_a, 32'h1234_5678);
      check("ld3_cnt0", ld_outstanding, 0);
      check("ld3_err", sb_err, 0);

      // Load return and ALU write colliding on R5
      next_cycle();
      ld_issue = 1'b1; ld_dest = 4'd5;
      next_cycle();
      ld_valid = 1'b1; ld_ret_dest = 4'd5; ld_data = 32'h1111_1111;
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h2222_2222; rd_addr_a = 4'd5;
      #3;
      check("r5_bypass_alu", rd_data_a, 32'h2222_2222);
      next_cycle();
      rd_addr_a = 4'd5;
      #3;
      check("r5_alu_wins", rd_data_a, 32'h2222_2222);
      check("r5_busy", busy_a, 0);
      check("r5_cnt", ld_outstanding, 0);
      check("r5_err", sb_err, 0);

      // ALU write to busy R6, then same-cycle issue and return to R6
      next_cycle();
      ld_issue = 1'b1; ld_dest = 4'd6;
      next_cycle();
      wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h0000_0066; rd_addr_a = 4'd6;
      #3;
      check("r6_busy_pre", busy_a, 1);
      next_cycle();
      rd_addr_a = 4'd6;
      #3;
      check("r6_alu_data", rd_data_a, 32'h0000_0066);
      check("r6_still_busy", busy_a, 1);
      next_cycle();
      ld_issue = 1'b1; ld_dest = 4'd6; ld_valid = 1'b1; ld_ret_dest = 4'd6; ld_data = 32'h0000_0077;
      rd_addr_a = 4'd6;
      #3;
      check("r6_ret_masks_busy", busy_a, 0);
      check("r6_ld_bypass", rd_data_a, 32'h0000_0077);
      next_cycle();
      rd_addr_a = 4'd6;
      #3;
      check("r6_reissue_busy", busy_a, 1);
      check("r6_cnt_hold", ld_outstanding, 1);
      check("r6_err", sb_err, 0);
      check("r6_data", rd_data_a, 32'h0000_0077);
      next_cycle();
      ld_valid = 1'b1; ld_ret_dest = 4'd6; ld_data = 32'h0000_0088;
      next_cycle();
      rd_addr_a = 4'd6;
      #3;
      check("r6_final_cnt", ld_outstanding, 0);
      check("r6_final_busy", busy_a, 0);
      check("r6_final_data", rd_data_a, 32'h0000_0088);

      // Protocol errors: double issue, then return to an idle index
      next_cycle();
      ld_issue = 1'b1; ld_dest = 4'd2;
      next_cycle();
      ld_issue = 1'b1; ld_dest = 4'd2; rd_addr_a = 4'd2;
      #3;
      check("dbl_err_pre", sb_err, 0);
      next_cycle();
      rd_addr_a = 4'd2;
      #3;
      check("dbl_err", sb_err, 1);
      check("dbl_cnt", ld_outstanding, 1);
      check("dbl_busy", busy_a, 1);
      next_cycle();
      ld_valid = 1'b1; ld_ret_dest = 4'd7; ld_data = 32'h7777_0007;
      next_cycle();
      rd_addr_a = 4'd7;
      #3;
      check("idle_ret_err", sb_err, 1);
      check("idle_ret_cnt", ld_outstanding, 1);
      check("idle_ret_data", rd_data_a, 32'h7777_0007);

      // Four more loads in flight, then asynchronous reset between edges
      for (int d = 9; d <= 12; d++) begin
         next_cycle();
         ld_issue = 1'b1; ld_dest = 4'(d);
      end
      next_cycle();
      rd_addr_a = 4'd9; rd_addr_b = 4'd5;
      #1;
      check("pre_rst_cnt", ld_outstanding, 5);
      check("pre_rst_stall", stall, 1);
      check("pre_rst_r5", rd_data_b, 32'h2222_2222);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_cnt", ld_outstanding, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_r5", rd_data_b, 0);
      check("mid_rst_err", sb_err, 0);
      idle();
      #1;
      reset = 1'b1;

      // Stale return after reset, and a load aimed at the PC alias
      next_cycle();
      ld_valid = 1'b1; ld_ret_dest = 4'd9; ld_data = 32'h9999_0009;
      next_cycle();
      rd_addr_a = 4'd9; rd_addr_b = 4'd15; pc_val = 32'h0000_0044;
      ld_issue = 1'b1; ld_dest = 4'd15;
      #3;
      check("stale_ret_data", rd_data_a, 32'h9999_0009);
      check("stale_ret_err", sb_err, 1);
      check("stale_ret_cnt", ld_outstanding, 0);
      check("pc_busy_b", busy_b, 0);
      check("pc_read_b", rd_data_b, 32'h0000_0044);
      next_cycle();
      rd_addr_b = 4'd15;
      #3;
      check("pc_issue_cnt", ld_outstanding, 0);
      check("pc_issue_stall", stall, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
